// File: rtl/fab_wdt_pkg.sv
// Shared types and helpers for the fabric watchdog.
package fab_wdt_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARMED     = 2'b01,
    RESETTING = 2'b10,
    HOLDOFF   = 2'b11
  } wdt_state_t;

  localparam int TRIP_COUNT_MAX = 255;

  // One counter serves every state; it only has to reach (largest limit - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/fab_wdt_sync.sv
// Multi-flop input synchronizer with a registered-history rising-edge strobe.
module fab_wdt_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign dout = chain[SYNC_STAGES-1];
  assign rise = dout & ~prev;

endmodule

// File: rtl/fab_watchdog.sv
// Fabric watchdog: arms on GPIO enable, expects periodic kicks, and pulses
// FAB_RESET_N low when the MSS stops kicking.
module fab_watchdog
  import fab_wdt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES     = 50000000,
  parameter int RESET_PULSE_CYCLES = 1024,
  parameter int HOLDOFF_CYCLES     = 4096,
  parameter int SYNC_STAGES        = 2
) (
  input  logic       CLK_BASE,
  input  logic       RESET,
  input  logic       MSS_READY,
  input  logic       WDT_ENABLE,
  input  logic       WDT_KICK,
  output logic       FAB_RESET_N,
  output logic       WDT_EXPIRED,
  output logic [7:0] TRIP_COUNT,
  output logic [1:0] WDT_STATE
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES, RESET_PULSE_CYCLES, HOLDOFF_CYCLES);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] P_LAST = CW'(RESET_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLDOFF_CYCLES - 1);

  logic ready_s, en_s, kick_s, kick;
  logic ready_rise, en_rise;
  logic unused_rise;

  fab_wdt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ready (
    .clk(CLK_BASE), .rst(RESET), .din(MSS_READY), .dout(ready_s), .rise(ready_rise)
  );
  fab_wdt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
    .clk(CLK_BASE), .rst(RESET), .din(WDT_ENABLE), .dout(en_s), .rise(en_rise)
  );
  fab_wdt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_kick (
    .clk(CLK_BASE), .rst(RESET), .din(WDT_KICK), .dout(kick_s), .rise(kick)
  );

  // Ready/enable are level-qualified only; kick level is only needed for its edge.
  assign unused_rise = ready_rise ^ en_rise ^ kick_s;

  wdt_state_t    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK_BASE) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      FAB_RESET_N <= 1'b1;
      WDT_EXPIRED <= 1'b0;
      TRIP_COUNT  <= '0;
    end else begin
      WDT_EXPIRED <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (ready_s && en_s) state <= ARMED;
        end
        ARMED: begin
          // Disarm beats terminal count; a kick beats terminal count.
          if (!ready_s || !en_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (kick) begin
            cnt <= '0;
          end else if (cnt == T_LAST) begin
            state       <= RESETTING;
            cnt         <= '0;
            FAB_RESET_N <= 1'b0;
            WDT_EXPIRED <= 1'b1;
            if (TRIP_COUNT != 8'(TRIP_COUNT_MAX)) TRIP_COUNT <= TRIP_COUNT + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESETTING: begin
          if (cnt == P_LAST) begin
            state       <= HOLDOFF;
            cnt         <= '0;
            FAB_RESET_N <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLDOFF: begin
          if (cnt == H_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign WDT_STATE = state;

endmodule

// File: tb/tb_fab_watchdog.sv
// Directed bench for fab_watchdog with short timeouts (16/4/8, 2-stage sync).
module tb_fab_watchdog;

  localparam int T = 16, P = 4, H = 8, S = 2;

  logic       CLK_BASE = 1'b0;
  logic       RESET = 1'b1, MSS_READY = 1'b0, WDT_ENABLE = 1'b0, WDT_KICK = 1'b0;
  logic       FAB_RESET_N, WDT_EXPIRED;
  logic [7:0] TRIP_COUNT;
  logic [1:0] WDT_STATE;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK_BASE = ~CLK_BASE;

  fab_watchdog #(
    .TIMEOUT_CYCLES(T), .RESET_PULSE_CYCLES(P), .HOLDOFF_CYCLES(H), .SYNC_STAGES(S)
  ) dut (
    .CLK_BASE(CLK_BASE), .RESET(RESET), .MSS_READY(MSS_READY), .WDT_ENABLE(WDT_ENABLE),
    .WDT_KICK(WDT_KICK), .FAB_RESET_N(FAB_RESET_N), .WDT_EXPIRED(WDT_EXPIRED),
    .TRIP_COUNT(TRIP_COUNT), .WDT_STATE(WDT_STATE)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK_BASE);
      #1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1; MSS_READY = 1'b0; WDT_ENABLE = 1'b0; WDT_KICK = 1'b0;
    step(3);
    RESET = 1'b0;
  endtask

  // Levels land in the FSM on the third edge after they change.
  task automatic arm();
    MSS_READY = 1'b1; WDT_ENABLE = 1'b1;
    step(2);
    chk("arm_latency", WDT_STATE, 0);
    step(1);
    chk("armed", WDT_STATE, 1);
  endtask

  initial begin
    int bad, seen, cyc;

    // Reset then idle
    step(3);
    RESET = 1'b0;
    chk("rst_fab_n", FAB_RESET_N, 1);
    chk("rst_trip", TRIP_COUNT, 0);
    chk("rst_state", WDT_STATE, 0);
    chk("rst_expired", WDT_EXPIRED, 0);
    MSS_READY = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (FAB_RESET_N !== 1'b1 || WDT_STATE !== 2'd0 || WDT_EXPIRED !== 1'b0 || TRIP_COUNT !== 8'd0)
        bad++;
    end
    chk("idle_hold", bad, 0);

    // Regular kicks every 10 cycles
    do_reset();
    arm();
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      WDT_KICK = ((i % 10) < 5);
      step(1);
      if (WDT_STATE !== 2'd1 || WDT_EXPIRED !== 1'b0 || FAB_RESET_N !== 1'b1) bad++;
    end
    chk("kick_hold", bad, 0);
    chk("kick_trip", TRIP_COUNT, 0);

    // Timeout: trip after 16 armed cycles, 4 low, 8 holdoff, then idle
    do_reset();
    arm();
    step(15);
    chk("to_pre_state", WDT_STATE, 1);
    chk("to_pre_exp", WDT_EXPIRED, 0);
    step(1);
    chk("to_state", WDT_STATE, 2);
    chk("to_expired", WDT_EXPIRED, 1);
    chk("to_fab_low", FAB_RESET_N, 0);
    chk("to_trip", TRIP_COUNT, 1);
    WDT_ENABLE = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (FAB_RESET_N !== 1'b0 || WDT_STATE !== 2'd2 || WDT_EXPIRED !== 1'b0) bad++;
    end
    chk("to_pulse", bad, 0);
    step(1);
    chk("to_release", FAB_RESET_N, 1);
    chk("to_holdoff", WDT_STATE, 3);
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (WDT_STATE !== 2'd3 || FAB_RESET_N !== 1'b1) bad++;
    end
    chk("to_holdoff_len", bad, 0);
    step(1);
    chk("to_idle", WDT_STATE, 0);
    step(5);
    chk("to_idle_stay", WDT_STATE, 0);

    // Kick reaching the FSM exactly at terminal count
    do_reset();
    arm();
    step(13);
    WDT_KICK = 1'b1;
    step(3);
    chk("tc_kick_state", WDT_STATE, 1);
    chk("tc_kick_exp", WDT_EXPIRED, 0);
    chk("tc_kick_trip", TRIP_COUNT, 0);
    WDT_KICK = 1'b0;
    step(15);
    chk("tc_restart_armed", WDT_STATE, 1);
    step(1);
    chk("tc_restart_trip", WDT_STATE, 2);
    chk("tc_restart_cnt", TRIP_COUNT, 1);

    // Disarm at counter=10, then MSS_READY drop
    do_reset();
    arm();
    step(8);
    WDT_ENABLE = 1'b0;
    step(2);
    chk("dis_still_armed", WDT_STATE, 1);
    step(1);
    chk("dis_idle", WDT_STATE, 0);
    step(20);
    chk("dis_no_trip", TRIP_COUNT, 0);
    chk("dis_fab", FAB_RESET_N, 1);
    WDT_ENABLE = 1'b1;
    step(3);
    chk("rearm", WDT_STATE, 1);
    step(5);
    MSS_READY = 1'b0;
    step(2);
    chk("mss_still_armed", WDT_STATE, 1);
    step(1);
    chk("mss_idle", WDT_STATE, 0);
    step(20);
    chk("mss_no_trip", TRIP_COUNT, 0);
    chk("mss_state", WDT_STATE, 0);

    // 257 back-to-back trips, then reset in the middle of a pulse
    do_reset();
    MSS_READY = 1'b1; WDT_ENABLE = 1'b1;
    seen = 0; cyc = 0; bad = 0;
    while (seen < 257 && cyc < 12000) begin
      step(1);
      cyc++;
      if (WDT_EXPIRED === 1'b1) begin
        seen++;
        if (TRIP_COUNT !== 8'((seen < 255) ? seen : 255)) bad++;
      end
    end
    chk("sat_trips_seen", seen, 257);
    chk("sat_track", bad, 0);
    chk("sat_count", TRIP_COUNT, 255);
    chk("sat_state", WDT_STATE, 2);
    step(1);
    chk("mid_pulse_low", FAB_RESET_N, 0);
    RESET = 1'b1;
    step(1);
    chk("mid_rst_fab", FAB_RESET_N, 1);
    chk("mid_rst_trip", TRIP_COUNT, 0);
    chk("mid_rst_state", WDT_STATE, 0);
    MSS_READY = 1'b0; WDT_ENABLE = 1'b0;
    step(1);
    RESET = 1'b0;
    step(5);
    chk("post_rst_idle", WDT_STATE, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
